sum_accum: RTL and testbench

SUM_ACCUM -- requirements
Module: sum_accum

---
 rtl/sum_accum_if.sv | 35 +++
 rtl/sum_accum.sv | 121 ++++++++++++
 tb/tb_sum_accum.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sum_accum_if.sv
// ============================================================================
// Interface : sum_accum_if
// Purpose   : Input-sample and frame-result handshake bundle for sum_accum.
//             master = upstream producer / downstream consumer side,
//             slave  = the accumulator itself.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sum_accum_if #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 40
);
  logic [WIDTH-1:0]     sum;
  logic                 in_valid;
  logic                 in_ready;
  logic                 flush;
  logic [ACC_WIDTH-1:0] acc_out;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           count;
  logic                 ovf;

  modport master (
    output sum, in_valid, flush, out_ready,
    input  in_ready, acc_out, out_valid, count, ovf
  );

  modport slave (
    input  sum, in_valid, flush, out_ready,
    output in_ready, acc_out, out_valid, count, ovf
  );
endinterface

`default_nettype wire

// File: rtl/sum_accum.sv
// ============================================================================
// Module   : sum_accum
// Purpose  : Accumulates FRAME_LEN unsigned sum words (or fewer on flush)
//            into one frame total, then holds it until the consumer takes it.
// Options  : define SUM_ACCUM_SAT_EN to clamp the total at all-ones on
//            overflow instead of wrapping modulo 2^ACC_WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_accum #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 40,
  parameter int FRAME_LEN = 8
) (
  input  wire logic    clk,
  input  wire logic    rst,
  sum_accum_if.slave   io_bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] c_frame_len = 8'(FRAME_LEN);

  state_t               r_state, w_state_nxt;
  logic [ACC_WIDTH-1:0] r_acc, w_acc_nxt;
  logic [7:0]           r_count, w_count_nxt;
  logic                 r_ovf, w_ovf_nxt;

  logic                 w_in_ready;
  logic                 w_accept;
  logic [ACC_WIDTH-1:0] w_sum_ext;
  logic [ACC_WIDTH:0]   w_add;
  logic                 w_carry;
  logic [ACC_WIDTH-1:0] w_acc_add;
  logic [7:0]           w_count_inc;

  // One extra bit on the adder exposes the carry out of the accumulator.
  assign w_sum_ext   = {{(ACC_WIDTH-WIDTH){1'b0}}, io_bus.sum};
  assign w_add       = {1'b0, r_acc} + {1'b0, w_sum_ext};
  assign w_carry     = w_add[ACC_WIDTH];
  assign w_count_inc = r_count + 8'd1;

`ifdef SUM_ACCUM_SAT_EN
  // Once the frame has overflowed the total stays pinned at all-ones.
  assign w_acc_add = (w_carry || r_ovf) ? {ACC_WIDTH{1'b1}} : w_add[ACC_WIDTH-1:0];
`else
  assign w_acc_add = w_add[ACC_WIDTH-1:0];
`endif

  assign w_in_ready       = (r_state != S_HOLD);
  assign w_accept         = io_bus.in_valid && w_in_ready;

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = (r_state == S_HOLD);
  assign io_bus.acc_out   = r_acc;
  assign io_bus.count     = r_count;
  assign io_bus.ovf       = r_ovf;

  // Next-state and datapath update for the frame controller.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      S_IDLE: begin
        // First sample of a new frame; flush here only matters with an accept.
        if (w_accept) begin
          w_acc_nxt   = w_sum_ext;
          w_count_nxt = 8'd1;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = ((c_frame_len == 8'd1) || io_bus.flush) ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          w_acc_nxt   = w_acc_add;
          w_count_nxt = w_count_inc;
          w_ovf_nxt   = r_ovf | w_carry;
          if ((w_count_inc == c_frame_len) || io_bus.flush) begin
            w_state_nxt = S_HOLD;
          end
        end else if (io_bus.flush) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        // Result stays visible in IDLE until the next frame starts.
        if (io_bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_count <= 8'd0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sum_accum.sv
// ============================================================================
// Module   : tb_sum_accum
// Purpose  : Self-checking bench for sum_accum: directed vector table,
//            hand-written frame sequences and a randomized run against a
//            frame-level reference model. Honours SUM_ACCUM_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sum_accum;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  // a: default configuration, w: 33-bit accumulator, f: one-sample frames
  sum_accum_if #(.WIDTH(32), .ACC_WIDTH(40)) bus_a ();
  sum_accum_if #(.WIDTH(32), .ACC_WIDTH(33)) bus_w ();
  sum_accum_if #(.WIDTH(32), .ACC_WIDTH(40)) bus_f ();

  sum_accum #(.WIDTH(32), .ACC_WIDTH(40), .FRAME_LEN(8)) u_a (
    .clk(clk), .rst(rst), .io_bus(bus_a.slave));
  sum_accum #(.WIDTH(32), .ACC_WIDTH(33), .FRAME_LEN(8)) u_w (
    .clk(clk), .rst(rst), .io_bus(bus_w.slave));
  sum_accum #(.WIDTH(32), .ACC_WIDTH(40), .FRAME_LEN(1)) u_f (
    .clk(clk), .rst(rst), .io_bus(bus_f.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv_a(input logic v, input logic [31:0] s, input logic f, input logic r);
    bus_a.in_valid  = v;
    bus_a.sum       = s;
    bus_a.flush     = f;
    bus_a.out_ready = r;
  endtask

  task automatic drv_w(input logic v, input logic [31:0] s, input logic f, input logic r);
    bus_w.in_valid  = v;
    bus_w.sum       = s;
    bus_w.flush     = f;
    bus_w.out_ready = r;
  endtask

  // ---------------- frame-level reference model for bus_w -----------------
  localparam longint unsigned c_W_MAX = (64'd1 << 33) - 64'd1;
  longint unsigned m_frame[$];
  bit              m_hold;
  bit              m_open;

  function automatic longint unsigned m_true_total();
    longint unsigned t = 0;
    foreach (m_frame[i]) t += m_frame[i];
    return t;
  endfunction

  function automatic longint unsigned m_acc();
    longint unsigned t = m_true_total();
`ifdef SUM_ACCUM_SAT_EN
    return (t > c_W_MAX) ? c_W_MAX : t;
`else
    return t & c_W_MAX;
`endif
  endfunction

  task automatic m_step(input bit r_st, input bit v, input longint unsigned s, input bit f, input bit r);
    if (r_st) begin
      m_frame.delete();
      m_hold = 1'b0;
      m_open = 1'b0;
    end else if (m_hold) begin
      if (r) m_hold = 1'b0;
    end else begin
      if (v) begin
        if (!m_open) m_frame.delete();
        m_frame.push_back(s);
        m_open = 1'b1;
      end
      if (m_open && (f || m_frame.size() == 8)) begin
        m_hold = 1'b1;
        m_open = 1'b0;
      end
    end
  endtask

  // ---------------- directed vector table for bus_a -----------------------
  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] s;
    logic        f;
    logic        r;
    logic        ov;
    logic        ir;
    logic [7:0]  cnt;
    logic [39:0] acc;
    logic        ovf;
  } vec_t;

  vec_t tbl[11];

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    drv_a(1'b0, 32'd0, 1'b0, 1'b0);
    drv_w(1'b0, 32'd0, 1'b0, 1'b0);
    bus_f.in_valid = 1'b0; bus_f.sum = 32'd0; bus_f.flush = 1'b0; bus_f.out_ready = 1'b0;

    //          rst   v     s       f     r     ov    ir    cnt    acc      ovf
    tbl[0]  = '{1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 40'd0,  1'b0};
    tbl[1]  = '{1'b0, 1'b1, 32'd5,  1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 40'd5,  1'b0};
    tbl[2]  = '{1'b0, 1'b1, 32'd5,  1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 40'd10, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 32'd5,  1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 40'd15, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 32'd7,  1'b1, 1'b0, 1'b1, 1'b0, 8'd4, 40'd22, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 32'd99, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4, 40'd22, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'd99, 1'b0, 1'b1, 1'b0, 1'b1, 8'd4, 40'd22, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 32'd99, 1'b1, 1'b0, 1'b0, 1'b1, 8'd4, 40'd22, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 32'd3,  1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 40'd3,  1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 40'd3,  1'b0};
    tbl[10] = '{1'b1, 1'b1, 32'd8,  1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 40'd0,  1'b0};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst;
      drv_a(tbl[i].v, tbl[i].s, tbl[i].f, tbl[i].r);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), 64'(bus_a.out_valid), 64'(tbl[i].ov));
      chk($sformatf("vec%0d_in_ready", i),  64'(bus_a.in_ready),  64'(tbl[i].ir));
      chk($sformatf("vec%0d_count", i),     64'(bus_a.count),     64'(tbl[i].cnt));
      chk($sformatf("vec%0d_acc_out", i),   64'(bus_a.acc_out),   64'(tbl[i].acc));
      chk($sformatf("vec%0d_ovf", i),       64'(bus_a.ovf),       64'(tbl[i].ovf));
    end
    rst = 1'b0;

    // ---- full frame of 50s, result one cycle after the 8th accept ----
    for (int k = 1; k <= 8; k++) begin
      chk("frame50_out_valid_pre", 64'(bus_a.out_valid), 64'd0);
      drv_a(1'b1, 32'd50, 1'b0, 1'b1);
      @(negedge clk);
      chk("frame50_count", 64'(bus_a.count), 64'(k));
    end
    chk("frame50_out_valid", 64'(bus_a.out_valid), 64'd1);
    chk("frame50_acc_out",   64'(bus_a.acc_out),   64'd400);
    chk("frame50_ovf",       64'(bus_a.ovf),       64'd0);
    drv_a(1'b0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("frame50_released", 64'(bus_a.out_valid), 64'd0);

    // ---- back-pressure: held frame with in_valid asserted throughout ----
    for (int k = 1; k <= 8; k++) begin
      drv_a(1'b1, 32'(k), 1'b0, 1'b0);
      @(negedge clk);
    end
    for (int k = 0; k < 5; k++) begin
      drv_a(1'b1, 32'd100, 1'b0, 1'b0);
      @(negedge clk);
      chk("hold_in_ready",  64'(bus_a.in_ready),  64'd0);
      chk("hold_out_valid", 64'(bus_a.out_valid), 64'd1);
      chk("hold_acc_out",   64'(bus_a.acc_out),   64'd36);
      chk("hold_count",     64'(bus_a.count),     64'd8);
    end
    drv_a(1'b1, 32'd100, 1'b0, 1'b1);
    @(negedge clk);
    chk("release_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("release_in_ready",  64'(bus_a.in_ready),  64'd1);
    chk("release_acc_out",   64'(bus_a.acc_out),   64'd36);
    drv_a(1'b1, 32'd100, 1'b0, 1'b0);
    @(negedge clk);
    chk("after_release_count", 64'(bus_a.count),   64'd1);
    chk("after_release_acc",   64'(bus_a.acc_out), 64'd100);

    // ---- reset mid-frame, then a clean frame of ones ----
    rst = 1'b1;
    drv_a(1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drv_a(1'b1, 32'd9, 1'b0, 1'b0);
      @(negedge clk);
    end
    chk("mid_count", 64'(bus_a.count),   64'd4);
    chk("mid_acc",   64'(bus_a.acc_out), 64'd36);
    rst = 1'b1;
    drv_a(1'b1, 32'd9, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_count",     64'(bus_a.count),     64'd0);
    chk("rst_acc",       64'(bus_a.acc_out),   64'd0);
    chk("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus_a.in_ready),  64'd1);
    for (int k = 0; k < 8; k++) begin
      drv_a(1'b1, 32'd1, 1'b0, 1'b0);
      @(negedge clk);
    end
    chk("ones_out_valid", 64'(bus_a.out_valid), 64'd1);
    chk("ones_acc",       64'(bus_a.acc_out),   64'd8);
    chk("ones_count",     64'(bus_a.count),     64'd8);
    drv_a(1'b0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    drv_a(1'b0, 32'd0, 1'b0, 1'b0);

    // ---- FRAME_LEN=1: one frame every two cycles ----
    for (int c = 0; c < 8; c++) begin
      bus_f.in_valid  = 1'b1;
      bus_f.out_ready = 1'b1;
      bus_f.sum       = 32'(10 + c / 2);
      chk("f1_in_ready", 64'(bus_f.in_ready), 64'((c % 2) == 0));
      @(negedge clk);
      if ((c % 2) == 0) begin
        chk("f1_out_valid", 64'(bus_f.out_valid), 64'd1);
        chk("f1_acc_out",   64'(bus_f.acc_out),   64'(10 + c / 2));
        chk("f1_count",     64'(bus_f.count),     64'd1);
      end else begin
        chk("f1_out_valid", 64'(bus_f.out_valid), 64'd0);
      end
    end
    bus_f.in_valid  = 1'b0;
    bus_f.out_ready = 1'b0;

    // ---- 33-bit accumulator overflow ----
    for (int k = 0; k < 2; k++) begin
      drv_w(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
      @(negedge clk);
    end
    chk("w33_two_ovf", 64'(bus_w.ovf),     64'd0);
    chk("w33_two_acc", 64'(bus_w.acc_out), 64'h1FFFFFFFE);
    for (int k = 0; k < 6; k++) begin
      drv_w(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
      @(negedge clk);
    end
    chk("w33_ovf",       64'(bus_w.ovf),       64'd1);
    chk("w33_out_valid", 64'(bus_w.out_valid), 64'd1);
`ifdef SUM_ACCUM_SAT_EN
    chk("w33_acc_sat",  64'(bus_w.acc_out), 64'h1FFFFFFFF);
`else
    chk("w33_acc_wrap", 64'(bus_w.acc_out), 64'h1FFFFFFF8);
`endif
    drv_w(1'b0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    drv_w(1'b1, 32'd1, 1'b0, 1'b0);
    @(negedge clk);
    chk("w33_ovf_cleared", 64'(bus_w.ovf),     64'd0);
    chk("w33_new_acc",     64'(bus_w.acc_out), 64'd1);

    // ---- randomized run on bus_w against the frame model ----
    rst = 1'b1;
    drv_w(1'b0, 32'd0, 1'b0, 1'b0);
    m_step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    for (int c = 0; c < 600; c++) begin
      bit              r_st, v, f, r;
      logic [31:0]     s;
      chk("rnd_out_valid", 64'(bus_w.out_valid), 64'(m_hold));
      chk("rnd_in_ready",  64'(bus_w.in_ready),  64'(!m_hold));
      chk("rnd_count",     64'(bus_w.count),     64'(m_frame.size()));
      chk("rnd_acc_out",   64'(bus_w.acc_out),   m_acc());
      chk("rnd_ovf",       64'(bus_w.ovf),       64'(m_true_total() > c_W_MAX));
      r_st = ($urandom_range(0, 79) == 0);
      v    = ($urandom_range(0, 3) != 0);
      f    = ($urandom_range(0, 9) == 0);
      r    = ($urandom_range(0, 1) == 1);
      s    = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1000));
      rst  = r_st;
      drv_w(v, s, f, r);
      m_step(r_st, v, 64'(s), f, r);
      @(negedge clk);
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
